// File: rtl/alu_issue_unit.sv
// alu_issue_unit: registered ALU front end with an in-order response FIFO.
// Define ALU_ISSUE_CHECK_EN to add a per-entry result check and an error counter.
module alu_issue_unit #(
  parameter int DEPTH = 4,
  parameter int DW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [DW-1:0] req_a,
  input  logic [DW-1:0] req_b,
  input  logic [2:0]    req_op,
  input  logic [1:0]    req_func,
  output logic [DW-1:0] InputA,
  output logic [DW-1:0] InputB,
  output logic [2:0]    OP,
  output logic [1:0]    Function,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_zero,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_zero,
  output logic          busy
`ifdef ALU_ISSUE_CHECK_EN
  ,
  output logic          rsp_mismatch,
  output logic [7:0]    err_count
`endif
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
`ifdef ALU_ISSUE_CHECK_EN
  localparam int EW = DW + 2;
`else
  localparam int EW = DW + 1;
`endif
  typedef enum logic {IDLE, DRIVE} state_t;
  state_t r_state, w_next;
  logic [DW-1:0] r_a, r_b;
  logic [2:0] r_op;
  logic [1:0] r_func;
  logic [EW-1:0] r_mem [DEPTH];
  logic [EW-1:0] r_head, w_entry, w_head_n;
  logic [AW-1:0] r_wptr, r_rptr, w_rptr_n;
  logic [AW:0] r_count, w_count_n;
  logic w_accept, w_push, w_pop;
  always_ff @(posedge Clk)
    if (Reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    req_ready = (r_state == IDLE) && (r_count < DEPTH_C);
    w_accept = req_valid && req_ready;
    w_push = r_state == DRIVE;
    w_next = w_push ? IDLE : (w_accept ? DRIVE : IDLE);
  end
  assign busy = r_state == DRIVE;
  assign rsp_valid = r_count != '0;
  assign w_pop = rsp_valid && rsp_ready;
  assign w_rptr_n = w_pop ? r_rptr + AW'(1) : r_rptr;
  assign w_count_n = (w_push && !w_pop) ? r_count + ONE :
                     (!w_push && w_pop) ? r_count - ONE : r_count;
  // A push into a slot the read pointer is about to land on bypasses the memory
  assign w_head_n = (w_push && w_rptr_n == r_wptr) ? w_entry : r_mem[w_rptr_n];
`ifdef ALU_ISSUE_CHECK_EN
  logic [DW-1:0] w_ref;
  logic w_known, w_mm;
  logic [7:0] r_err;
  assign w_known = (r_op == 3'd0) || ((r_op == 3'd2 || r_op == 3'd3) && !r_func[1]);
  assign w_ref = (r_op == 3'd0) ? r_a + r_b :
                 (r_op == 3'd2) ? (r_func[0] ? r_a - r_b : r_a | r_b) :
                 (r_func[0] ? r_a >> r_b : r_a << r_b);
  assign w_mm = w_known && (w_ref != alu_out);
  assign w_entry = {alu_out, alu_zero, w_mm};
  assign rsp_mismatch = r_head[0];
  assign err_count = r_err;
  always_ff @(posedge Clk)
    if (Reset) r_err <= '0;
    else if (w_push && w_mm && r_err != 8'hFF) r_err <= r_err + 8'd1;
`else
  assign w_entry = {alu_out, alu_zero};
`endif
  assign rsp_data = r_head[EW-1 -: DW];
  assign rsp_zero = r_head[EW-DW-1];
  assign InputA = r_a;
  assign InputB = r_b;
  assign OP = r_op;
  assign Function = r_func;
  always_ff @(posedge Clk)
    if (w_push) r_mem[r_wptr] <= w_entry;
  always_ff @(posedge Clk)
    if (Reset) begin
      r_a <= '0;
      r_b <= '0;
      r_op <= '0;
      r_func <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
      r_head <= '0;
    end else begin
      if (w_accept) begin
        r_a <= req_a;
        r_b <= req_b;
        r_op <= req_op;
        r_func <= req_func;
      end
      if (w_push) r_wptr <= r_wptr + AW'(1);
      r_rptr <= w_rptr_n;
      r_count <= w_count_n;
      if (w_count_n != '0) r_head <= w_head_n;
    end
endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: random and directed traffic against a queue-based model of the issue unit.
module tb_alu_issue_unit;
  localparam int DEPTH = 4;
  localparam int DW = 8;
  logic Clk = 0, Reset = 1, req_valid = 0, rsp_ready = 0, corrupt = 0;
  logic [7:0] req_a = 0, req_b = 0;
  logic [2:0] req_op = 0;
  logic [1:0] req_func = 0;
  logic req_ready, rsp_valid, rsp_zero, busy, alu_zero;
  logic [7:0] InputA, InputB, rsp_data, alu_out;
  logic [2:0] OP;
  logic [1:0] Function;
`ifdef ALU_ISSUE_CHECK_EN
  logic rsp_mismatch;
  logic [7:0] err_count;
`endif
  alu_issue_unit #(.DEPTH(DEPTH), .DW(DW)) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_func(req_func),
    .InputA(InputA), .InputB(InputB), .OP(OP), .Function(Function),
    .alu_out(alu_out), .alu_zero(alu_zero), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .busy(busy)
`ifdef ALU_ISSUE_CHECK_EN
    , .rsp_mismatch(rsp_mismatch), .err_count(err_count)
`endif
  );
  always #5 Clk = ~Clk;
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic [1:0] f);
    if (op == 3'd0) return a + b;
    if (op == 3'd2 && f == 2'd0) return a | b;
    if (op == 3'd2 && f == 2'd1) return a - b;
    if (op == 3'd3 && f == 2'd0) return (b >= 8) ? 8'd0 : 8'(a << b);
    if (op == 3'd3 && f == 2'd1) return (b >= 8) ? 8'd0 : 8'(a >> b);
    return a ^ b ^ 8'h5A;
  endfunction
  function automatic bit known(input logic [2:0] op, input logic [1:0] f);
    return op == 3'd0 || (op == 3'd2 && f < 2'd2) || (op == 3'd3 && f < 2'd2);
  endfunction
  assign alu_out = corrupt ? 8'h00 : alu_f(InputA, InputB, OP, Function);
  assign alu_zero = alu_out == 8'h00;
  typedef struct packed {logic [7:0] d; logic z; logic m;} rsp_t;
  rsp_t q[$];
  rsp_t r;
  int checks = 0, failures = 0, acc_n = 0, err_m = 0;
  bit inflight = 0;
  logic [7:0] la = 0, lb = 0, ld = 0;
  logic [2:0] lop = 0;
  logic [1:0] lf = 0;
  logic lz = 0;
  logic [7:0] exp3 [3];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic cycle();
    bit acc, pop;
    int cnt;
    @(negedge Clk);
    cnt = q.size() - int'(inflight);
    check("req_ready", 32'(req_ready), 32'(!inflight && q.size() < DEPTH));
    check("rsp_valid", 32'(rsp_valid), 32'(cnt > 0));
    check("busy", 32'(busy), 32'(inflight));
    check("InputA", 32'(InputA), 32'(la));
    check("InputB", 32'(InputB), 32'(lb));
    check("OP", 32'(OP), 32'(lop));
    check("Function", 32'(Function), 32'(lf));
    check("rsp_data", 32'(rsp_data), 32'(cnt > 0 ? q[0].d : ld));
    check("rsp_zero", 32'(rsp_zero), 32'(cnt > 0 ? q[0].z : lz));
`ifdef ALU_ISSUE_CHECK_EN
    if (cnt > 0) check("rsp_mismatch", 32'(rsp_mismatch), 32'(q[0].m));
    check("err_count", 32'(err_count), 32'(err_m));
`endif
    acc = req_valid && !inflight && q.size() < DEPTH;
    pop = rsp_ready && cnt > 0;
    @(posedge Clk);
    #1;
    if (Reset) begin
      q.delete();
      inflight = 0;
      la = 0; lb = 0; lop = 0; lf = 0; ld = 0; lz = 0; err_m = 0;
    end else begin
      if (inflight && q[q.size()-1].m && err_m < 255) err_m++;
      inflight = 0;
      if (pop) begin
        ld = q[0].d;
        lz = q[0].z;
        void'(q.pop_front());
      end
      if (acc) begin
        r.d = corrupt ? 8'h00 : alu_f(req_a, req_b, req_op, req_func);
        r.z = r.d == 8'h00;
        r.m = corrupt && known(req_op, req_func) && alu_f(req_a, req_b, req_op, req_func) != 8'h00;
        q.push_back(r);
        la = req_a; lb = req_b; lop = req_op; lf = req_func;
        inflight = 1;
        acc_n++;
      end
    end
  endtask
  task automatic offer(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic [1:0] f);
    int n0;
    n0 = acc_n;
    req_a = a; req_b = b; req_op = op; req_func = f; req_valid = 1;
    for (int i = 0; i < 20 && acc_n == n0; i++) cycle();
    req_valid = 0;
    if (acc_n == n0) check("offer_timeout", 32'(0), 32'(1));
  endtask
  initial begin
    exp3[0] = 8'h03; exp3[1] = 8'h08; exp3[2] = 8'h02;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 0;
    repeat (3) cycle();
    check("idle_ready", 32'(req_ready), 32'(1));
    offer(8'd1, 8'd1, 3'd0, 2'd0);
    check("add_InputA", 32'(InputA), 32'(1));
    check("add_OP", 32'(OP), 32'(0));
    cycle();
    check("add_valid", 32'(rsp_valid), 32'(1));
    check("add_data", 32'(rsp_data), 32'(2));
    check("add_zero", 32'(rsp_zero), 32'(0));
    rsp_ready = 1;
    cycle();
    rsp_ready = 0;
    offer(8'd4, 8'd1, 3'd2, 2'd1);
    offer(8'd4, 8'd1, 3'd3, 2'd0);
    offer(8'd4, 8'd1, 3'd3, 2'd1);
    rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      check("order", 32'(rsp_data), 32'(exp3[i]));
      cycle();
    end
    rsp_ready = 0;
    cycle();
    begin
      int n0;
      n0 = acc_n;
      req_a = 8'd9; req_b = 8'd3; req_op = 3'd2; req_func = 2'd0; req_valid = 1;
      repeat (12) cycle();
      check("full_acc", 32'(acc_n - n0), 32'(4));
      check("full_ready", 32'(req_ready), 32'(0));
      rsp_ready = 1;
      cycle();
      rsp_ready = 0;
      check("refill_ready", 32'(req_ready), 32'(1));
      cycle();
      req_valid = 0;
      check("full_acc5", 32'(acc_n - n0), 32'(5));
    end
    rsp_ready = 1;
    repeat (8) cycle();
    rsp_ready = 0;
    offer(8'd7, 8'd2, 3'd0, 2'd0);
    Reset = 1;
    cycle();
    Reset = 0;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_valid", 32'(rsp_valid), 32'(0));
    repeat (4) cycle();
`ifdef ALU_ISSUE_CHECK_EN
    corrupt = 1;
    offer(8'd4, 8'd1, 3'd0, 2'd0);
    cycle();
    check("chk_mm", 32'(rsp_mismatch), 32'(1));
    check("chk_err", 32'(err_count), 32'(1));
    rsp_ready = 1;
    cycle();
    rsp_ready = 0;
    offer(8'd4, 8'd1, 3'd1, 2'd0);
    cycle();
    check("chk_nomm", 32'(rsp_mismatch), 32'(0));
    check("chk_err2", 32'(err_count), 32'(1));
    corrupt = 0;
    rsp_ready = 1;
    repeat (2) cycle();
    rsp_ready = 0;
`endif
    for (int i = 0; i < 3000; i++) begin
      Reset = $urandom_range(0, 199) == 0;
      req_valid = 1'($urandom_range(0, 1));
      req_a = 8'($urandom);
      req_b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
      req_op = 3'($urandom_range(0, 7));
      req_func = 2'($urandom_range(0, 3));
      rsp_ready = $urandom_range(0, 2) != 0;
      cycle();
    end
    Reset = 0;
    req_valid = 0;
    rsp_ready = 1;
    repeat (8) cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Sequential front end for the 8-bit ALU.
- Accepts operation requests on a valid/ready handshake, drives registered InputA/InputB/OP/Function into the combinational ALU, then captures Out/Zero.
- Returns results in order through a small response FIFO with its own valid/ready handshake.
- Sits between the control/decode path and the ALU, replacing ad hoc direct drive of ALU inputs.

Parameters:
- DEPTH, 4, response FIFO entries; power of two, 2 to 16.
- DW, 8, operand and result width; must match the ALU.

Ports:
- Clk  input  1  system clock, all state on rising edge.
- Reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_a  input  DW  operand A.
- req_b  input  DW  operand B.
- req_op  input  3  ALU opcode.
- req_func  input  2  ALU function field.
- InputA  output  DW  registered operand A to ALU.
- InputB  output  DW  registered operand B to ALU.
- OP  output  3  registered opcode to ALU.
- Function  output  2  registered function to ALU.
- alu_out  input  DW  ALU Out.
- alu_zero  input  1  ALU Zero.
- rsp_valid  output  1  FIFO head valid.
- rsp_ready  input  1  consumer takes head this cycle.
- rsp_data  output  DW  head result.
- rsp_zero  output  1  head Zero flag.
- busy  output  1  an operation is in flight (state != IDLE).

Behaviour:
- Reset (synchronous, Reset high at a rising Clk edge):
  - Outputs: InputA=0, InputB=0, OP=0, Function=0, rsp_valid=0, rsp_data=0, rsp_zero=0, busy=0.
  - State returns to IDLE, FIFO is emptied, pointers and count are zeroed.
  - Reset wins over every other event in the same cycle. An in-flight op is discarded with no response.
- States: IDLE, DRIVE.
  - IDLE: req_ready = (count + 0) < DEPTH. On req_valid && req_ready, register req_* into InputA/InputB/OP/Function, then go to DRIVE.
  - DRIVE: req_ready=0. ALU inputs are stable for the whole cycle. At the end of the cycle, push {alu_out, alu_zero} into the FIFO, then go to IDLE.
- ALU input registers hold their last values in IDLE; they are not cleared after use.
- Throughput: one op per 2 cycles maximum.
- Latency: request accepted at edge N, result pushed at edge N+1, rsp_valid high from cycle N+2 if the FIFO was empty.
- FIFO:
  - Head is shown on rsp_data/rsp_zero whenever rsp_valid=1. rsp_data/rsp_zero hold their last value when the FIFO is empty.
  - Pop on rsp_valid && rsp_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Pointers wrap modulo DEPTH.
- Full handling: a request is only accepted when the FIFO has room for its result, so the DRIVE push can never overflow. When count == DEPTH, req_ready=0.
- Pop when empty: ignored.
- Results leave in strict request order.

Optional Feature:
- Macro: ALU_ISSUE_CHECK_EN.
- When defined, the unit adds:
  - An output rsp_mismatch (1 bit, stored per FIFO entry).
  - An output err_count (8 bits, saturating at 255, cleared by Reset).
- In DRIVE, an internal reference model is compared with alu_out:
  - op 0: A+B.
  - op 2, func 0: A|B.
  - op 2, func 1: A-B.
  - op 3, func 0: A<<B.
  - op 3, func 1: A>>B.
  - All arithmetic is mod 2^DW. Shifts by B ≥ DW give 0.
  - Any other op/func pair is unchecked and forces mismatch=0.
- A mismatch stores rsp_mismatch=1 with the entry and increments err_count.
- Without the macro, neither port exists and no comparison logic is built.

Test Plan:
- Reset, then idle 3 cycles -> rsp_valid=0, busy=0, req_ready=1, OP=0, InputA=0.
- Request A=1, B=1, op=0, func=0 with ALU model attached -> OP=0 and InputA=1 one cycle after acceptance; rsp_valid at N+2 with rsp_data=0x02, rsp_zero=0.
- Back-to-back requests (4,1,op2,f1), (4,1,op3,f0), (4,1,op3,f1) with rsp_ready=0 -> req_ready low on each DRIVE cycle; FIFO then returns 0x03, 0x08, 0x02 in order.
- DEPTH=4 with rsp_ready=0 and 5 requests offered -> 4 accepted, req_ready stays 0 afterward; one rsp_ready pulse -> req_ready returns to 1 the next IDLE cycle.
- Request in flight (DRIVE) when Reset is asserted -> next cycle: state IDLE, rsp_valid=0, no result ever appears.
- With ALU_ISSUE_CHECK_EN defined and alu_out forced to 0x00 for 4+1 (op0) -> rsp_mismatch=1, err_count=1. An op=1 request gives mismatch=0.
